// File: rtl/raster_motion_ctrl.sv
// raster_motion_ctrl: raster coordinate generator and once-per-frame
// bouncing object sequencer for the overlay datapath.
//
// Ports
//   clk_i     video clock
//   rst_n_i   async active-low reset
//   cen_i     clock enable; every register holds while low
//   fvht_i    timing bus {F,V,H,T}
//   run_i     motion enable, sampled at frame start
//   speed_i   pixels/lines per frame, latched at frame start
//   fvht_o    fvht_i delayed one enabled cycle
//   x_o/y_o   pixel / line index inside the active raster
//   active_o  high when H=0 and V=0
//   obj_x_o/obj_y_o  object top-left corner
//   frame_o   pulse on V falling edge
//   bounce_o  pulse {y_bounce, x_bounce} when a direction flips
//   state_o   0 IDLE, 1 ACTIVE, 2 UPDATE
module raster_motion_ctrl #(
  parameter int unsigned H_ACTIVE = 1920,
  parameter int unsigned V_ACTIVE = 1080,
  parameter int unsigned OBJ_W    = 950,
  parameter int unsigned OBJ_H    = 250,
  parameter int unsigned X0       = 750,
  parameter int unsigned Y0       = 450
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        cen_i,
  input  logic [3:0]  fvht_i,
  input  logic        run_i,
  input  logic [3:0]  speed_i,
  output logic [3:0]  fvht_o,
  output logic [15:0] x_o,
  output logic [15:0] y_o,
  output logic        active_o,
  output logic [15:0] obj_x_o,
  output logic [15:0] obj_y_o,
  output logic        frame_o,
  output logic [1:0]  bounce_o,
  output logic [1:0]  state_o
);

  localparam int unsigned CW = 16;
  localparam int unsigned AW = 17;

  localparam logic [CW-1:0] X_MAX  = CW'(H_ACTIVE - 1);
  localparam logic [CW-1:0] Y_MAX  = CW'(V_ACTIVE - 1);
  localparam logic [CW-1:0] OX_MAX = CW'(H_ACTIVE - OBJ_W);
  localparam logic [CW-1:0] OY_MAX = CW'(V_ACTIVE - OBJ_H);
  localparam logic [CW-1:0] X_RST  = CW'(X0);
  localparam logic [CW-1:0] Y_RST  = CW'(Y0);
  localparam logic [AW-1:0] H_LIM  = AW'(H_ACTIVE);
  localparam logic [AW-1:0] V_LIM  = AW'(V_ACTIVE);
  localparam logic [AW-1:0] W_OBJ  = AW'(OBJ_W);
  localparam logic [AW-1:0] H_OBJ  = AW'(OBJ_H);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_UPDATE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            h_q, v_q, seen_q;
  logic            dir_x_q, dir_y_q;   // 1 = moving towards 0
  logic [3:0]      speed_q;
  logic            h_in, v_in, act_in, v_fall, h_rise;
  logic [CW+1:0]   step_x, step_y;     // {bounce, dir, pos}

  // One axis of motion; 17-bit arithmetic keeps the sum from wrapping.
  function automatic logic [CW+1:0] axis_step(
    input logic [CW-1:0] pos,
    input logic          dir,
    input logic [3:0]    s,
    input logic [AW-1:0] size,
    input logic [AW-1:0] lim,
    input logic [CW-1:0] max_pos
  );
    logic [AW-1:0] p;
    logic [AW-1:0] sp;
    p  = {1'b0, pos};
    sp = AW'(s);
    axis_step = {1'b0, dir, pos};
    // Zero speed never reaches the bounce branches, so no spurious pulse.
    if (s != 4'd0) begin
      if (!dir) begin
        if (p + sp + size >= lim) axis_step = {1'b1, 1'b1, max_pos};
        else                      axis_step = {1'b0, 1'b0, CW'(p + sp)};
      end else begin
        if (p <= sp) axis_step = {1'b1, 1'b0, {CW{1'b0}}};
        else         axis_step = {1'b0, 1'b1, CW'(p - sp)};
      end
    end
  endfunction

  assign h_in   = fvht_i[1];
  assign v_in   = fvht_i[2];
  assign act_in = ~h_in & ~v_in;
  // Previous samples are meaningless until one enabled cycle has passed.
  assign v_fall = seen_q & v_q & ~v_in;
  assign h_rise = seen_q & ~h_q & h_in;

  // Next state and per-axis motion.
  always_comb begin
    state_d = state_q;
    step_x  = axis_step(obj_x_o, dir_x_q, speed_q, W_OBJ, H_LIM, OX_MAX);
    step_y  = axis_step(obj_y_o, dir_y_q, speed_q, H_OBJ, V_LIM, OY_MAX);
    if (cen_i) begin
      case (state_q)
        S_IDLE:   if (v_fall) state_d = S_ACTIVE;
        S_ACTIVE: if (v_fall && run_i) state_d = S_UPDATE;
        S_UPDATE: state_d = S_ACTIVE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  assign state_o = state_q;

  // Raster counters, edge history and object registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      seen_q   <= 1'b0;
      h_q      <= 1'b0;
      v_q      <= 1'b0;
      fvht_o   <= 4'd0;
      active_o <= 1'b0;
      frame_o  <= 1'b0;
      x_o      <= '0;
      y_o      <= '0;
      speed_q  <= 4'd0;
      obj_x_o  <= X_RST;
      obj_y_o  <= Y_RST;
      dir_x_q  <= 1'b0;
      dir_y_q  <= 1'b0;
      bounce_o <= 2'b00;
    end else if (cen_i) begin
      seen_q   <= 1'b1;
      h_q      <= h_in;
      v_q      <= v_in;
      fvht_o   <= fvht_i;
      active_o <= act_in;
      frame_o  <= v_fall;
      if (v_fall) speed_q <= speed_i;

      // x restarts at 0 on the first active pixel of each line.
      if (h_in)        x_o <= '0;
      else if (act_in) x_o <= !active_o ? '0 : (x_o >= X_MAX) ? X_MAX : x_o + 16'd1;

      if (v_in)        y_o <= '0;
      else if (h_rise) y_o <= (y_o >= Y_MAX) ? Y_MAX : y_o + 16'd1;

      bounce_o <= 2'b00;
      if (state_q == S_UPDATE) begin
        obj_x_o  <= step_x[CW-1:0];
        dir_x_q  <= step_x[CW];
        obj_y_o  <= step_y[CW-1:0];
        dir_y_q  <= step_y[CW];
        bounce_o <= {step_y[CW+1], step_x[CW+1]};
      end
    end
  end

endmodule

// File: tb/tb_raster_motion_ctrl.sv
// Directed bench for raster_motion_ctrl: default-size instance (u_a) and a
// small-raster instance (u_b) sharing the same stimulus.
module tb_raster_motion_ctrl;

  logic        clk = 1'b0;
  logic        rst_n_i;
  logic        cen_i;
  logic [3:0]  fvht_i;
  logic        run_i;
  logic [3:0]  speed_i;

  logic [3:0]  a_fvht, b_fvht;
  logic [15:0] a_x, a_y, a_ox, a_oy, b_x, b_y, b_ox, b_oy;
  logic        a_act, a_frame, b_act, b_frame;
  logic [1:0]  a_b, a_st, b_b, b_st;

  raster_motion_ctrl u_a (
    .clk_i(clk), .rst_n_i(rst_n_i), .cen_i(cen_i), .fvht_i(fvht_i),
    .run_i(run_i), .speed_i(speed_i), .fvht_o(a_fvht), .x_o(a_x), .y_o(a_y),
    .active_o(a_act), .obj_x_o(a_ox), .obj_y_o(a_oy), .frame_o(a_frame),
    .bounce_o(a_b), .state_o(a_st)
  );

  raster_motion_ctrl #(
    .H_ACTIVE(40), .V_ACTIVE(30), .OBJ_W(10), .OBJ_H(10), .X0(10), .Y0(0)
  ) u_b (
    .clk_i(clk), .rst_n_i(rst_n_i), .cen_i(cen_i), .fvht_i(fvht_i),
    .run_i(run_i), .speed_i(speed_i), .fvht_o(b_fvht), .x_o(b_x), .y_o(b_y),
    .active_o(b_act), .obj_x_o(b_ox), .obj_y_o(b_oy), .frame_o(b_frame),
    .bounce_o(b_b), .state_o(b_st)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        run;
    logic [3:0]  speed;
    logic        half;
    logic [1:0]  st;
    logic [15:0] ox;
    logic [15:0] oy;
    logic [1:0]  b;
  } vec_t;

  vec_t tbl[$];
  bit   use_b;
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic half);
    if (half) begin
      cen_i = 1'b0;
      tick();
    end
    cen_i = 1'b1;
    tick();
  endtask

  task automatic add(input logic run, input int s, input logic half,
                     input int st, input int ox, input int oy, input int b);
    vec_t v;
    v.run = run; v.speed = 4'(s); v.half = half; v.st = 2'(st);
    v.ox = 16'(ox); v.oy = 16'(oy); v.b = 2'(b);
    tbl.push_back(v);
  endtask

  function automatic int c_ox();    return use_b ? int'(b_ox)    : int'(a_ox);    endfunction
  function automatic int c_oy();    return use_b ? int'(b_oy)    : int'(a_oy);    endfunction
  function automatic int c_st();    return use_b ? int'(b_st)    : int'(a_st);    endfunction
  function automatic int c_b();     return use_b ? int'(b_b)     : int'(a_b);     endfunction
  function automatic int c_frame(); return use_b ? int'(b_frame) : int'(a_frame); endfunction

  // One vertical blank, V fall, UPDATE cycle and one more cycle.
  task automatic do_frame(input vec_t v);
    fvht_i = 4'b0110; run_i = v.run; speed_i = v.speed;
    step(v.half);
    step(v.half);
    fvht_i = 4'b0000;
    step(v.half);
    chk("frame_pulse", c_frame(), 1);
    chk("state_after_fall", c_st(), int'(v.st));
    speed_i = 4'hF;  // must be ignored until the next frame start
    if (v.half) begin
      cen_i = 1'b0;
      tick();
      chk("hold_frame", c_frame(), 1);
      chk("hold_state", c_st(), int'(v.st));
    end
    cen_i = 1'b1;
    tick();
    chk("obj_x", c_ox(), int'(v.ox));
    chk("obj_y", c_oy(), int'(v.oy));
    chk("bounce", c_b(), int'(v.b));
    chk("state_settled", c_st(), 1);
    step(v.half);
    chk("bounce_clear", c_b(), 0);
    chk("frame_clear", c_frame(), 0);
  endtask

  task automatic run_table();
    for (int i = 0; i < tbl.size(); i++) begin
      do_frame(tbl[i]);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    rst_n_i = 1'b0; cen_i = 1'b1; fvht_i = 4'd0; run_i = 1'b0; speed_i = 4'd0;
    tick();
    tick();
    chk("rst_state", int'(a_st), 0);
    chk("rst_obj_x", int'(a_ox), 750);
    chk("rst_obj_y", int'(a_oy), 450);
    chk("rst_x", int'(a_x), 0);
    chk("rst_fvht", int'(a_fvht), 0);
    chk("rst_bounce", int'(a_b), 0);
    @(negedge clk);
    rst_n_i = 1'b1;

    // Motion on the full-size raster.
    use_b = 1'b0;
    add(1, 3, 0, 1, 750, 450, 0);
    add(1, 3, 0, 2, 753, 453, 0);
    add(1, 3, 0, 2, 756, 456, 0);
    add(1, 3, 0, 2, 759, 459, 0);
    for (int k = 1; k <= 13; k++) add(1, 15, 0, 2, 759 + 15 * k, 459 + 15 * k, 0);
    add(1, 14, 0, 2, 968, 668, 0);
    add(1, 3, 0, 2, 970, 671, 1);
    add(1, 3, 0, 2, 967, 674, 0);
    add(0, 5, 0, 1, 967, 674, 0);
    add(0, 5, 0, 1, 967, 674, 0);
    add(1, 0, 0, 2, 967, 674, 0);
    add(1, 2, 1, 2, 965, 676, 0);
    add(1, 2, 1, 2, 963, 678, 0);
    run_table();

    // Raster with the object frozen.
    cen_i = 1'b1; run_i = 1'b0; fvht_i = 4'b0110;
    tick();
    tick();
    chk("vblank_y", int'(a_y), 0);
    chk("vblank_x", int'(a_x), 0);
    chk("vblank_active", int'(a_act), 0);
    chk("vblank_fvht", int'(a_fvht), 6);
    for (int k = 0; k < 1925; k++) begin
      logic [3:0] fv;
      fv = {3'b000, k[0]};
      fvht_i = fv;
      tick();
      chk("line_x", int'(a_x), (k < 1919) ? k : 1919);
      chk("line_active", int'(a_act), 1);
      chk("line_fvht", int'(a_fvht), int'(fv));
      if (k == 0) begin
        chk("raster_frame", int'(a_frame), 1);
        chk("frozen_state", int'(a_st), 1);
        chk("frozen_x", int'(a_ox), 963);
        chk("frozen_y", int'(a_oy), 678);
      end
    end
    fvht_i = 4'b0010;
    tick();
    chk("hblank_x", int'(a_x), 0);
    chk("hblank_active", int'(a_act), 0);
    chk("hblank_y", int'(a_y), 1);
    for (int n = 1; n <= 1085; n++) begin
      fvht_i = 4'b0000;
      tick();
      chk("short_y", int'(a_y), (n < 1079) ? n : 1079);
      chk("short_x", int'(a_x), 0);
      chk("short_active", int'(a_act), 1);
      fvht_i = 4'b0010;
      tick();
      chk("short_y_next", int'(a_y), (n + 1 < 1079) ? n + 1 : 1079);
    end

    // Asynchronous reset in the middle of a line.
    fvht_i = 4'b0000;
    tick();
    tick();
    #2 rst_n_i = 1'b0;
    #1;
    chk("async_x", int'(a_x), 0);
    chk("async_y", int'(a_y), 0);
    chk("async_obj_x", int'(a_ox), 750);
    chk("async_obj_y", int'(a_oy), 450);
    chk("async_state", int'(a_st), 0);
    chk("async_active", int'(a_act), 0);
    chk("async_b_obj_x", int'(b_ox), 10);
    @(negedge clk);
    rst_n_i = 1'b1;
    tbl.delete();
    add(1, 3, 0, 1, 750, 450, 0);
    add(1, 3, 0, 2, 753, 453, 0);
    run_table();

    // Small raster: simultaneous and left/top bounces.
    rst_n_i = 1'b0;
    tick();
    tick();
    @(negedge clk);
    rst_n_i = 1'b1;
    use_b = 1'b1;
    tbl.delete();
    add(1, 5, 0, 1, 10, 0, 0);
    add(1, 5, 0, 2, 15, 5, 0);
    add(1, 5, 0, 2, 20, 10, 0);
    add(1, 5, 0, 2, 25, 15, 0);
    add(1, 5, 0, 2, 30, 20, 3);
    add(1, 5, 0, 2, 25, 15, 0);
    add(1, 5, 0, 2, 20, 10, 0);
    add(1, 5, 0, 2, 15, 5, 0);
    add(1, 5, 0, 2, 10, 0, 2);
    add(1, 5, 0, 2, 5, 5, 0);
    add(1, 3, 0, 2, 2, 8, 0);
    add(1, 3, 0, 2, 0, 11, 1);
    run_table();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
